div_result_packer: RTL

- Sits directly downstream of the pipelined `divider`, between it and the AFU's channel-1 write path.
- Tracks which divider issue slots carry real operands and captures `div_result` exactly LATENCY cycles after each accepted issue.
- Buffers captured results in a credit-managed FIFO and packs them into 512-bit cache lines, so the AFU writes one line per WORDS quotients instead of one line per quotient.

---
 rtl/div_result_packer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/div_result_packer.sv
// Captures divider results LATENCY cycles after each accepted issue, buffers them
// in a credit-managed FIFO and packs them into LINE_BITS-wide lines for the AFU.
module div_result_packer #(
  parameter int DATA_LEN  = 32,
  parameter int LATENCY   = 11,
  parameter int LINE_BITS = 512,
  parameter int DEPTH     = 32
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        issue_valid,
  output logic                                        issue_ready,
  input  logic [DATA_LEN-1:0]                         div_result,
  input  logic                                        flush,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [LINE_BITS-1:0]                        out_data,
  output logic [$clog2(LINE_BITS/DATA_LEN+1)-1:0]     out_count,
  output logic                                        busy
);

  localparam int WORDS = LINE_BITS / DATA_LEN;
  localparam int CW    = $clog2(WORDS + 1);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW    = $clog2(DEPTH + 1);

  typedef enum logic {FILL, EMIT} state_t;

  state_t              state;
  logic [LATENCY-1:0]  valid_line;
  logic [FW-1:0]       inflight;
  logic [FW-1:0]       fifo_count;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [CW-1:0]       widx;
  logic [LINE_BITS-1:0] line;
  logic                flush_pending;
  logic                flush_line;

  logic                accept;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic [FW:0]         credit_used;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits cover both buffered and still-in-divider results, so the FIFO cannot overflow.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue_ready = !reset && (credit_used < (FW+1)'(DEPTH));
  assign accept      = issue_valid && issue_ready;
  assign push        = valid_line[LATENCY-1];
  assign fifo_empty  = (fifo_count == '0);
  assign pop         = (state == FILL) && !fifo_empty;

  assign out_data = line;
  assign busy     = (inflight != '0) || !fifo_empty || (widx != '0) ||
                    (state == EMIT) || flush_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_line <= '0;
    end else begin
      // NOTE: non-blocking, so every stage takes the previous stage's old value and the bit walks one slot per cycle.
      valid_line[0] <= accept;
      for (int i = 1; i < LATENCY; i++) valid_line[i] <= valid_line[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({accept, push})
        2'b10:   inflight <= inflight + FW'(1);
        2'b01:   inflight <= inflight - FW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + FW'(1);
      else if (pop && !push) fifo_count <= fifo_count - FW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= div_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FILL;
      widx          <= '0;
      line          <= '0;
      flush_pending <= 1'b0;
      flush_line    <= 1'b0;
      out_valid     <= 1'b0;
      out_count     <= '0;
    end else begin
      if (flush) flush_pending <= 1'b1;
      case (state)
        FILL: begin
          if (pop) begin
            line[widx*DATA_LEN +: DATA_LEN] <= mem[rd_ptr];
            widx <= widx + CW'(1);
            if (widx == CW'(WORDS - 1)) begin
              state      <= EMIT;
              out_valid  <= 1'b1;
              out_count  <= CW'(WORDS);
              flush_line <= 1'b0;
            end
          end else if (flush_pending && inflight == '0) begin
            // Everything has drained: ship the partial line, or drop an empty flush.
            if (widx != '0) begin
              state      <= EMIT;
              out_valid  <= 1'b1;
              out_count  <= widx;
              flush_line <= 1'b1;
            end else if (!flush) begin
              flush_pending <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            state     <= FILL;
            out_valid <= 1'b0;
            out_count <= '0;
            line      <= '0;
            widx      <= '0;
            if (flush_line && !flush) flush_pending <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
